dsp_engine_sequencer: RTL and testbench

Parametrised multi-channel frame sequencer for the DSP engine core.
- Accepts one frame of n_channels input samples and processes the channels one at a time.
- Per channel: input-gain unit, then a tick broadcast to n_pipelines parallel pipelines, then the output mixer.
- Collects the mixed results into an output frame.
- Sits between the sample I/O interface and the gain/pipeline/mixer datapath; it replaces the single-channel, two-pipeline fixed sequencing.

---
 rtl/dsp_engine_sequencer_if.sv | 42 ++++
 rtl/dsp_engine_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_dsp_engine_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_engine_sequencer_if.sv
// rtl/dsp_engine_sequencer_if.sv - datapath handshake bundle between the frame sequencer and the gain/pipeline/mixer units
//
// Purpose: carries the per-channel gain request/ack, pipeline tick/ready join
//          and mixer request/ack signals.
// Modports:
//   master - sequencer side (drives the requests, the tick and the pipeline sample/channel)
//   slave  - datapath side (drives the acks, the results and the pipeline ready/enable flags)
// Parameters:
//   data_width  - sample width in bits
//   n_pipelines - number of pipelines in the ready join
//   ch_width    - width of the channel index

interface dsp_engine_sequencer_if #(
    parameter int data_width  = 16,
    parameter int n_pipelines = 2,
    parameter int ch_width    = 1
);
    logic                   gain_req;
    logic [data_width-1:0]  gain_sample;
    logic                   gain_ack;
    logic [data_width-1:0]  gain_result;

    logic                   pipe_tick;
    logic [data_width-1:0]  pipe_sample;
    logic [ch_width-1:0]    pipe_channel;
    logic [n_pipelines-1:0] pipe_ready;
    logic [n_pipelines-1:0] pipe_enable;

    logic                   mix_req;
    logic                   mix_ack;
    logic [data_width-1:0]  mix_result;

    modport master (
        output gain_req, gain_sample, pipe_tick, pipe_sample, pipe_channel, mix_req,
        input  gain_ack, gain_result, pipe_ready, pipe_enable, mix_ack, mix_result
    );

    modport slave (
        input  gain_req, gain_sample, pipe_tick, pipe_sample, pipe_channel, mix_req,
        output gain_ack, gain_result, pipe_ready, pipe_enable, mix_ack, mix_result
    );
endinterface

// File: rtl/dsp_engine_sequencer.sv
// rtl/dsp_engine_sequencer.sv - multi-channel frame sequencer driving the gain, pipeline and mixer datapath
//
// Purpose: accepts one frame of n_channels samples, runs every channel through
//          gain -> pipeline tick/ready join -> mixer, and collects the mixed
//          samples into out_frame.
// Ports:
//   clk, rst_n     - clock (rising edge) and asynchronous active-low reset
//   in_frame       - input samples, channel k at [k*data_width +: data_width]
//   frame_valid    - strobe: in_frame valid (ignored and flagged as overrun when ready=0)
//   ready          - high while idle and able to accept a frame
//   dp             - datapath handshakes (dsp_engine_sequencer_if.master)
//   out_frame      - completed output frame, same packing as in_frame
//   out_valid      - strobe: out_frame updated
//   sample_ctr     - completed frame count, wraps
//   overrun        - sticky: frame_valid seen while ready=0
//   timeout        - sticky: watchdog abort (constant 0 without the watchdog)
//   clear_status   - clears overrun/timeout; a coincident set event wins
// Optional feature macro: DSP_SEQ_WATCHDOG_EN (per-wait watchdog with frame abort)

module dsp_engine_sequencer #(
    parameter int data_width     = 16,
    parameter int n_channels     = 2,
    parameter int n_pipelines    = 2,
    parameter int ctr_width      = 32,
    parameter int timeout_cycles = 4096,
    localparam int ch_width      = (n_channels > 1) ? $clog2(n_channels) : 1,
    localparam int frame_width   = n_channels * data_width
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [frame_width-1:0] in_frame,
    input  logic                   frame_valid,
    output logic                   ready,
    dsp_engine_sequencer_if.master dp,
    output logic [frame_width-1:0] out_frame,
    output logic                   out_valid,
    output logic [ctr_width-1:0]   sample_ctr,
    output logic                   overrun,
    output logic                   timeout,
    input  logic                   clear_status
);

    if (n_channels < 1 || n_pipelines < 1 || timeout_cycles < 2) begin : g_bad_param
        $error("dsp_engine_sequencer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAIN,
        S_PROC_WAIT,
        S_PROC,
        S_MIX
    } state_t;

    state_t                 state_q, state_d;
    logic [ch_width-1:0]    ch_q, ch_d;
    logic [frame_width-1:0] frame_q, frame_d;
    logic [frame_width-1:0] out_frame_q, out_frame_d;
    logic [data_width-1:0]  pipe_sample_q, pipe_sample_d;
    logic [ch_width-1:0]    pipe_channel_q, pipe_channel_d;
    logic [ctr_width-1:0]   sample_ctr_q, sample_ctr_d;
    logic                   gain_req_q, gain_req_d;
    logic                   pipe_tick_q, pipe_tick_d;
    logic                   mix_req_q, mix_req_d;
    logic                   out_valid_q, out_valid_d;
    logic                   ready_q, ready_d;
    logic                   overrun_q, overrun_d;

    logic                   accept;
    logic                   join_ok;
    logic                   last_ch;
    logic                   abort;
    logic [data_width-1:0]  gain_sample_mux;

    // ready_q is already 0 in the cycle after a frame completes, so a
    // frame_valid in that cycle is rejected as an overrun.
    assign accept  = (state_q == S_IDLE) && ready_q && frame_valid;
    // A disabled pipeline counts as ready; an all-zero enable mask always joins.
    assign join_ok = &(dp.pipe_ready | ~dp.pipe_enable);
    assign last_ch = (ch_q == ch_width'(n_channels - 1));

`ifdef DSP_SEQ_WATCHDOG_EN
    localparam int wait_width = $clog2(timeout_cycles + 1);

    logic [wait_width-1:0] wait_q, wait_d;
    logic                  timeout_q, timeout_d;
    logic                  waiting;
    logic                  progress;

    assign waiting  = (state_q == S_GAIN) || (state_q == S_PROC) || (state_q == S_MIX);
    // An ack or join arriving on the final cycle still wins over the abort.
    assign progress = ((state_q == S_GAIN) && dp.gain_ack) ||
                      ((state_q == S_PROC) && join_ok) ||
                      ((state_q == S_MIX)  && dp.mix_ack);
    assign abort    = waiting && !progress && (wait_q == wait_width'(timeout_cycles - 1));

    always_comb begin
        wait_d    = '0;
        timeout_d = (timeout_q && !clear_status) || abort;
        if (state_d == state_q && waiting) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register and all datapath/output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ch_q           <= '0;
            frame_q        <= '0;
            out_frame_q    <= '0;
            pipe_sample_q  <= '0;
            pipe_channel_q <= '0;
            sample_ctr_q   <= '0;
            gain_req_q     <= 1'b0;
            pipe_tick_q    <= 1'b0;
            mix_req_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            ready_q        <= 1'b1;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            frame_q        <= frame_d;
            out_frame_q    <= out_frame_d;
            pipe_sample_q  <= pipe_sample_d;
            pipe_channel_q <= pipe_channel_d;
            sample_ctr_q   <= sample_ctr_d;
            gain_req_q     <= gain_req_d;
            pipe_tick_q    <= pipe_tick_d;
            mix_req_q      <= mix_req_d;
            out_valid_q    <= out_valid_d;
            ready_q        <= ready_d;
            overrun_q      <= overrun_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept)      state_d = S_GAIN;
            S_GAIN:      if (dp.gain_ack) state_d = S_PROC_WAIT;
            S_PROC_WAIT:                  state_d = S_PROC;
            S_PROC:      if (join_ok)     state_d = S_MIX;
            S_MIX:       if (dp.mix_ack)  state_d = last_ch ? S_IDLE : S_GAIN;
            default:                      state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Output and datapath logic; strobes are registered so each is one cycle wide.
    always_comb begin
        ch_d           = ch_q;
        frame_d        = frame_q;
        out_frame_d    = out_frame_q;
        pipe_sample_d  = pipe_sample_q;
        pipe_channel_d = pipe_channel_q;
        sample_ctr_d   = sample_ctr_q;
        gain_req_d     = 1'b0;
        pipe_tick_d    = 1'b0;
        mix_req_d      = 1'b0;
        out_valid_d    = 1'b0;
        ready_d        = (state_q == S_IDLE) && (state_d == S_IDLE);
        overrun_d      = (overrun_q && !clear_status) || (frame_valid && !ready_q);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    frame_d    = in_frame;
                    ch_d       = '0;
                    gain_req_d = 1'b1;
                end
            end
            S_GAIN: begin
                if (dp.gain_ack) begin
                    pipe_sample_d  = dp.gain_result;
                    pipe_channel_d = ch_q;
                    pipe_tick_d    = 1'b1;
                end
            end
            S_PROC: begin
                if (join_ok) begin
                    mix_req_d = 1'b1;
                end
            end
            S_MIX: begin
                if (dp.mix_ack) begin
                    for (int i = 0; i < n_channels; i++) begin
                        if (ch_q == ch_width'(i)) begin
                            out_frame_d[i*data_width +: data_width] = dp.mix_result;
                        end
                    end
                    if (last_ch) begin
                        out_valid_d  = 1'b1;
                        sample_ctr_d = sample_ctr_q + 1'b1;
                    end else begin
                        ch_d       = ch_q + 1'b1;
                        gain_req_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Watchdog abort: every channel not yet mixed gets its dry input sample.
        if (abort) begin
            for (int i = 0; i < n_channels; i++) begin
                if (i >= int'(ch_q)) begin
                    out_frame_d[i*data_width +: data_width] = frame_q[i*data_width +: data_width];
                end
            end
            out_valid_d  = 1'b1;
            sample_ctr_d = sample_ctr_q + 1'b1;
            gain_req_d   = 1'b0;
            pipe_tick_d  = 1'b0;
            mix_req_d    = 1'b0;
        end
    end

    always_comb begin
        gain_sample_mux = '0;
        for (int i = 0; i < n_channels; i++) begin
            if (ch_q == ch_width'(i)) begin
                gain_sample_mux = frame_q[i*data_width +: data_width];
            end
        end
    end

    assign dp.gain_req     = gain_req_q;
    assign dp.gain_sample  = gain_sample_mux;
    assign dp.pipe_tick    = pipe_tick_q;
    assign dp.pipe_sample  = pipe_sample_q;
    assign dp.pipe_channel = pipe_channel_q;
    assign dp.mix_req      = mix_req_q;

    assign ready      = ready_q;
    assign out_frame  = out_frame_q;
    assign out_valid  = out_valid_q;
    assign sample_ctr = sample_ctr_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_dsp_engine_sequencer.sv
// tb/tb_dsp_engine_sequencer.sv - scoreboard bench for dsp_engine_sequencer

module tb_dsp_engine_sequencer;

    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int NP  = 2;
    localparam int CW  = 4;
    localparam int CHW = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH*DW-1:0] in_frame;
    logic              frame_valid;
    logic              ready;
    logic [NCH*DW-1:0] out_frame;
    logic              out_valid;
    logic [CW-1:0]     sample_ctr;
    logic              overrun;
    logic              timeout;
    logic              clear_status;

    dsp_engine_sequencer_if #(.data_width(DW), .n_pipelines(NP), .ch_width(CHW)) dp ();

    dsp_engine_sequencer #(
        .data_width    (DW),
        .n_channels    (NCH),
        .n_pipelines   (NP),
        .ctr_width     (CW),
        .timeout_cycles(4096)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_frame    (in_frame),
        .frame_valid (frame_valid),
        .ready       (ready),
        .dp          (dp),
        .out_frame   (out_frame),
        .out_valid   (out_valid),
        .sample_ctr  (sample_ctr),
        .overrun     (overrun),
        .timeout     (timeout),
        .clear_status(clear_status)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ov_count = 0;
    int stall_mode = 0;
    int tick_cyc = 0;
    int rise_cyc = 0;

    logic [NCH*DW-1:0] exp_frame_q[$];
    logic [CW-1:0]     exp_ctr_q[$];
    logic [CW-1:0]     exp_ctr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every out_valid pops one expected frame and count.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            ov_count++;
            if (exp_frame_q.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                chk("out_frame", out_frame, exp_frame_q.pop_front());
                chk("sample_ctr", sample_ctr, exp_ctr_q.pop_front());
            end
        end
    end

    // Timing monitor for the pipeline join.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dp.pipe_tick) tick_cyc = cyc;
            if (dp.mix_req) begin
                if (stall_mode == 1) chk("mix_after_ready_rise", 64'(cyc - rise_cyc), 64'd1);
                else                 chk("mix_after_tick", 64'(cyc - tick_cyc), 64'd2);
            end
        end
    end

    // Gain unit model: x2 after 3 cycles.
    initial begin : gain_resp
        logic [DW-1:0] s;
        dp.gain_ack    = 1'b0;
        dp.gain_result = '0;
        forever begin
            @(negedge clk);
            if (rst_n && dp.gain_req) begin
                s = dp.gain_sample;
                repeat (3) @(negedge clk);
                dp.gain_result = s << 1;
                dp.gain_ack    = 1'b1;
                @(negedge clk);
                dp.gain_ack    = 1'b0;
            end
        end
    end

    // Mixer model: returns the pipeline sample after 3 cycles.
    initial begin : mix_resp
        logic [DW-1:0] s;
        dp.mix_ack    = 1'b0;
        dp.mix_result = '0;
        forever begin
            @(negedge clk);
            if (rst_n && dp.mix_req) begin
                s = dp.pipe_sample;
                repeat (3) @(negedge clk);
                dp.mix_result = s;
                dp.mix_ack    = 1'b1;
                @(negedge clk);
                dp.mix_ack    = 1'b0;
            end
        end
    end

    // Pipeline 1 stall model: holds its ready low for 50 cycles after a tick.
    initial begin : stall_proc
        dp.pipe_ready = '1;
        forever begin
            @(negedge clk);
            if (rst_n && dp.pipe_tick && stall_mode != 0) begin
                dp.pipe_ready[1] = 1'b0;
                repeat (50) @(negedge clk);
                dp.pipe_ready[1] = 1'b1;
                rise_cyc = cyc;
            end
        end
    end

    task automatic send_frame(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        int n;
        n = 0;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_wait_timeout", {63'd0, ready}, 64'd1);
        in_frame    = {c1, c0};
        frame_valid = 1'b1;
        exp_ctr     = exp_ctr + 1'b1;
        exp_frame_q.push_back({e1, e0});
        exp_ctr_q.push_back(exp_ctr);
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_frame_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done", 64'(exp_frame_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin : global_guard
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        int cnt;
        int ovc0;
        in_frame       = '0;
        frame_valid    = 1'b0;
        clear_status   = 1'b0;
        dp.pipe_enable = '1;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_ready", {63'd0, ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_frame", out_frame, 64'd0);
        chk("reset_sample_ctr", sample_ctr, 64'd0);
        chk("reset_overrun", {63'd0, overrun}, 64'd0);
        chk("reset_timeout", {63'd0, timeout}, 64'd0);
        chk("reset_gain_req", {63'd0, dp.gain_req}, 64'd0);
        chk("reset_pipe_tick", {63'd0, dp.pipe_tick}, 64'd0);
        chk("reset_mix_req", {63'd0, dp.mix_req}, 64'd0);

        rst_n = 1'b1;
        @(negedge clk);

        // Basic frames, hand-computed x2 results (16-bit wrap).
        send_frame(16'h0100, 16'hFF00, 16'h0200, 16'hFE00); wait_done();
        chk("ready_after_frame", {63'd0, ready}, 64'd1);
        send_frame(16'h7FFF, 16'h8000, 16'hFFFE, 16'h0000); wait_done();
        send_frame(16'h0001, 16'hFFFF, 16'h0002, 16'hFFFE); wait_done();

        // Pipeline 1 stalled, included in the join.
        stall_mode = 1;
        send_frame(16'h1234, 16'h5678, 16'h2468, 16'hACF0); wait_done();
        stall_mode = 0;

        // Pipeline 1 stalled but excluded from the join.
        dp.pipe_enable = 2'b01;
        stall_mode = 2;
        send_frame(16'h0010, 16'h0020, 16'h0020, 16'h0040); wait_done();
        repeat (60) @(negedge clk);
        stall_mode = 0;

        // All pipelines disabled and not ready: join holds at once.
        dp.pipe_enable = 2'b00;
        dp.pipe_ready  = 2'b00;
        send_frame(16'h0300, 16'h0400, 16'h0600, 16'h0800); wait_done();
        dp.pipe_ready  = 2'b11;
        dp.pipe_enable = 2'b11;

        // Overrun mid-frame; first frame must complete unchanged.
        send_frame(16'h0100, 16'h0200, 16'h0200, 16'h0400);
        repeat (6) @(negedge clk);
        in_frame    = {16'hAAAA, 16'hBBBB};
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        chk("overrun_mid_frame", {63'd0, overrun}, 64'd1);
        wait_done();
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        chk("overrun_cleared", {63'd0, overrun}, 64'd0);

        // frame_valid in the out_valid cycle is an overrun and is dropped.
        send_frame(16'h0003, 16'h0004, 16'h0006, 16'h0008);
        n = 0;
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
        in_frame    = {16'h5555, 16'h6666};
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        chk("overrun_at_idle_return", {63'd0, overrun}, 64'd1);
        cnt = 0;
        repeat (10) begin
            if (dp.gain_req) cnt++;
            @(negedge clk);
        end
        chk("dropped_frame_no_gain_req", 64'(cnt), 64'd0);
        chk("ready_after_drop", {63'd0, ready}, 64'd1);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;

        // 16 frames: sample_ctr wraps 15 -> 0 along the way.
        for (int i = 0; i < 16; i++) begin
            send_frame(16'(i), 16'(i + 16'h10), 16'(2 * i), 16'(2 * i + 16'h20));
            wait_done();
        end
        chk("ctr_after_wrap", sample_ctr, exp_ctr);

        // Reset during MIX of channel 1 discards the frame.
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_frame    = {16'h0222, 16'h0111};
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        n = 0;
        while (!(dp.mix_req && dp.pipe_channel == 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mix_ch1_reached", {63'd0, dp.mix_req}, 64'd1);
        rst_n = 1'b0;
        ovc0  = ov_count;
        repeat (2) @(negedge clk);
        chk("midreset_ready", {63'd0, ready}, 64'd1);
        chk("midreset_sample_ctr", sample_ctr, 64'd0);
        chk("midreset_out_frame", out_frame, 64'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midreset_no_out_valid", 64'(ov_count - ovc0), 64'd0);
        chk("midreset_ctr_stays", sample_ctr, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
